// File: rtl/cv32e41s_clic_arbiter.sv
// CLIC arbiter: per-source interrupt configuration and pending state, with a
// registered highest-priority selection presented on the core's clic_irq_* interface.
module cv32e41s_clic_arbiter #(
  parameter int NUM_INTR      = 32,
  parameter int CLIC_ID_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_INTR-1:0]      intr_src_i,
  input  logic                     cfg_we_i,
  input  logic [CLIC_ID_WIDTH-1:0] cfg_id_i,
  input  logic [11:0]              cfg_wdata_i,
  output logic [11:0]              cfg_rdata_o,
  input  logic                     irq_ack_i,
  input  logic [CLIC_ID_WIDTH-1:0] irq_ack_id_i,
  output logic                     clic_irq_o,
  output logic [CLIC_ID_WIDTH-1:0] clic_irq_id_o,
  output logic [7:0]               clic_irq_level_o,
  output logic [1:0]               clic_irq_priv_o,
  output logic                     clic_irq_shv_o
);

  logic [NUM_INTR-1:0]      ie_q;
  logic [NUM_INTR-1:0]      trig_q;
  logic [NUM_INTR-1:0]      shv_q;
  logic [NUM_INTR-1:0]      ip_q;
  logic [NUM_INTR-1:0]      src_q;
  logic [7:0]               level_q [NUM_INTR];

  logic [31:0]              cfg_id_ext;
  logic [31:0]              ack_id_ext;
  logic [NUM_INTR-1:0]      cfg_hit;
  logic [NUM_INTR-1:0]      ack_hit;
  logic [NUM_INTR-1:0]      eligible;

  logic                     win_valid;
  logic [CLIC_ID_WIDTH-1:0] win_id;
  logic [7:0]               win_level;
  logic                     win_shv;

  assign cfg_id_ext = 32'(cfg_id_i);
  assign ack_id_ext = 32'(irq_ack_id_i);

  // Out-of-range IDs never match any source index, so they are dropped here.
  always_comb begin
    cfg_hit  = '0;
    ack_hit  = '0;
    eligible = '0;
    for (int unsigned i = 0; i < NUM_INTR; i++) begin
      cfg_hit[i]  = cfg_we_i  && (cfg_id_ext == i);
      ack_hit[i]  = irq_ack_i && (ack_id_ext == i);
      eligible[i] = ip_q[i] && ie_q[i] && (level_q[i] != 8'd0);
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    for (int unsigned i = 0; i < NUM_INTR; i++) begin
      if (cfg_id_ext == i) begin
        cfg_rdata_o = {ip_q[i], shv_q[i], trig_q[i], ie_q[i], level_q[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_INTR; i++) begin
      if (rst) begin
        ie_q[i]    <= 1'b0;
        trig_q[i]  <= 1'b0;
        shv_q[i]   <= 1'b0;
        ip_q[i]    <= 1'b0;
        src_q[i]   <= 1'b0;
        level_q[i] <= '0;
      end else begin
        src_q[i] <= intr_src_i[i];
        if (cfg_hit[i]) begin
          level_q[i] <= cfg_wdata_i[7:0];
          ie_q[i]    <= cfg_wdata_i[8];
          trig_q[i]  <= cfg_wdata_i[9];
          shv_q[i]   <= cfg_wdata_i[10];
        end
        // trig_q is the pre-write value, so a trig change takes effect one cycle later.
        if (!trig_q[i]) begin
          ip_q[i] <= intr_src_i[i];
        end else if (intr_src_i[i] && !src_q[i]) begin
          ip_q[i] <= 1'b1;
        end else if (cfg_hit[i]) begin
          ip_q[i] <= cfg_wdata_i[11];
        end else if (ack_hit[i]) begin
          ip_q[i] <= 1'b0;
        end
      end
    end
  end

  // Ascending scan with >= lets the higher ID win a level tie.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    win_level = '0;
    win_shv   = 1'b0;
    for (int unsigned i = 0; i < NUM_INTR; i++) begin
      if (eligible[i] && (!win_valid || (level_q[i] >= win_level))) begin
        win_valid = 1'b1;
        win_id    = CLIC_ID_WIDTH'(i);
        win_level = level_q[i];
        win_shv   = shv_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clic_irq_o       <= 1'b0;
      clic_irq_id_o    <= '0;
      clic_irq_level_o <= '0;
      clic_irq_shv_o   <= 1'b0;
    end else begin
      clic_irq_o <= win_valid;
      if (win_valid) begin
        clic_irq_id_o    <= win_id;
        clic_irq_level_o <= win_level;
        clic_irq_shv_o   <= win_shv;
      end
    end
  end

  assign clic_irq_priv_o = 2'b11;

endmodule

// File: tb/tb_cv32e41s_clic_arbiter.sv
// Directed bench for cv32e41s_clic_arbiter with hand-computed expectations.
module tb_cv32e41s_clic_arbiter;

  localparam int N  = 32;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  intr_src;
  logic          cfg_we;
  logic [IW-1:0] cfg_id;
  logic [11:0]   cfg_wdata;
  logic [11:0]   cfg_rdata;
  logic          irq_ack;
  logic [IW-1:0] irq_ack_id;
  logic          clic_irq;
  logic [IW-1:0] clic_irq_id;
  logic [7:0]    clic_irq_level;
  logic [1:0]    clic_irq_priv;
  logic          clic_irq_shv;

  int errors = 0;
  int checks = 0;

  cv32e41s_clic_arbiter #(.NUM_INTR(N), .CLIC_ID_WIDTH(IW)) dut (
    .clk              (clk),
    .rst              (rst),
    .intr_src_i       (intr_src),
    .cfg_we_i         (cfg_we),
    .cfg_id_i         (cfg_id),
    .cfg_wdata_i      (cfg_wdata),
    .cfg_rdata_o      (cfg_rdata),
    .irq_ack_i        (irq_ack),
    .irq_ack_id_i     (irq_ack_id),
    .clic_irq_o       (clic_irq),
    .clic_irq_id_o    (clic_irq_id),
    .clic_irq_level_o (clic_irq_level),
    .clic_irq_priv_o  (clic_irq_priv),
    .clic_irq_shv_o   (clic_irq_shv)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [IW-1:0] id, input logic [11:0] data);
    cfg_we    = 1'b1;
    cfg_id    = id;
    cfg_wdata = data;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic ack(input logic [IW-1:0] id);
    irq_ack    = 1'b1;
    irq_ack_id = id;
    step();
    irq_ack    = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    intr_src   = '1;
    cfg_we     = 1'b0;
    cfg_id     = 5'd3;
    cfg_wdata  = '0;
    irq_ack    = 1'b0;
    irq_ack_id = '0;
    step(); step(); step();
    chk("rst_irq",   32'(clic_irq), 32'h0);
    chk("rst_id",    32'(clic_irq_id), 32'h0);
    chk("rst_level", 32'(clic_irq_level), 32'h0);
    chk("rst_shv",   32'(clic_irq_shv), 32'h0);
    chk("rst_priv",  32'(clic_irq_priv), 32'h3);
    chk("rst_rdata", 32'(cfg_rdata), 32'h0);

    rst      = 1'b0;
    intr_src = '0;
    step();

    // Level source id 4
    cfg_write(5'd4, 12'h140);
    cfg_id = 5'd4;
    chk("lvl_rdata", 32'(cfg_rdata), 32'h140);
    intr_src[4] = 1'b1;
    step();
    chk("lvl_lat1", 32'(clic_irq), 32'h0);
    step();
    chk("lvl_irq",   32'(clic_irq), 32'h1);
    chk("lvl_id",    32'(clic_irq_id), 32'd4);
    chk("lvl_level", 32'(clic_irq_level), 32'h40);
    intr_src[4] = 1'b0;
    step();
    chk("lvl_drop1", 32'(clic_irq), 32'h1);
    step();
    chk("lvl_drop2", 32'(clic_irq), 32'h0);
    chk("lvl_hold_id", 32'(clic_irq_id), 32'd4);

    // Priority among 2, 5, 9
    cfg_write(5'd2, 12'h180);
    cfg_write(5'd9, 12'h180);
    cfg_write(5'd5, 12'h1C0);
    intr_src[2] = 1'b1;
    intr_src[5] = 1'b1;
    intr_src[9] = 1'b1;
    step(); step();
    chk("pri_id5",  32'(clic_irq_id), 32'd5);
    chk("pri_lvl5", 32'(clic_irq_level), 32'hC0);
    cfg_write(5'd5, 12'h0C0);
    chk("pri_dis_w", 32'(clic_irq_id), 32'd5);
    step();
    chk("pri_id9",  32'(clic_irq_id), 32'd9);
    chk("pri_lvl9", 32'(clic_irq_level), 32'h80);
    cfg_write(5'd9, 12'h100);
    step();
    chk("pri_id2", 32'(clic_irq_id), 32'd2);
    chk("pri_irq2", 32'(clic_irq), 32'h1);
    intr_src = '0;
    step(); step();
    chk("pri_idle", 32'(clic_irq), 32'h0);

    // Edge source id 7 with shv
    cfg_write(5'd7, 12'h720);
    intr_src[7] = 1'b1;
    step();
    intr_src[7] = 1'b0;
    step();
    chk("edge_irq",   32'(clic_irq), 32'h1);
    chk("edge_id",    32'(clic_irq_id), 32'd7);
    chk("edge_shv",   32'(clic_irq_shv), 32'h1);
    chk("edge_level", 32'(clic_irq_level), 32'h20);
    step();
    chk("edge_sticky", 32'(clic_irq), 32'h1);
    ack(5'd7);
    step();
    chk("edge_acked", 32'(clic_irq), 32'h0);

    // Collision: ack together with a new rising edge
    intr_src[7] = 1'b1;
    step();
    intr_src[7] = 1'b0;
    step();
    chk("col_pre", 32'(clic_irq), 32'h1);
    intr_src[7] = 1'b1;
    ack(5'd7);
    intr_src[7] = 1'b0;
    step();
    chk("col_irq", 32'(clic_irq), 32'h1);
    chk("col_id",  32'(clic_irq_id), 32'd7);
    cfg_id = 5'd7;
    chk("col_ip", 32'(cfg_rdata), 32'hF20);
    ack(5'd7);
    step();
    chk("col_clear", 32'(clic_irq), 32'h0);

    // Software pend on edge source id 11
    cfg_write(5'd11, 12'h310);
    cfg_id = 5'd11;
    chk("sw_cfg", 32'(cfg_rdata), 32'h310);
    cfg_write(5'd11, 12'hB10);
    step();
    chk("sw_irq",   32'(clic_irq), 32'h1);
    chk("sw_id",    32'(clic_irq_id), 32'd11);
    chk("sw_level", 32'(clic_irq_level), 32'h10);
    chk("sw_shv",   32'(clic_irq_shv), 32'h0);
    cfg_write(5'd11, 12'h310);
    step();
    chk("sw_unpend", 32'(clic_irq), 32'h0);

    // Reset mid-operation
    cfg_write(5'd11, 12'hB10);
    step();
    chk("mid_pre", 32'(clic_irq), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_irq",   32'(clic_irq), 32'h0);
    chk("mid_id",    32'(clic_irq_id), 32'h0);
    cfg_id = 5'd11;
    chk("mid_rdata", 32'(cfg_rdata), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv32e41s_clic_arbiter.md
# cv32e41s_clic_arbiter

Core-external CLIC arbitration block driving the core's CLIC interrupt interface (`clic_irq_*`). It holds per-source interrupt configuration (enable, trigger type, vectoring, level) and pending state. It selects the highest-priority pending-and-enabled source each cycle and presents it to the core on registered outputs. It consumes an acknowledge from the core to clear edge-triggered pending bits.

## Interface
- `NUM_INTR`, 32: number of interrupt sources, 2..1024.
- `CLIC_ID_WIDTH`, 5: ID width, must equal $clog2(NUM_INTR).
- `clk`  in  1: clock. One clock domain.
- `rst`  in  1: reset, synchronous, active-high.
- `intr_src_i`  in  NUM_INTR: raw source lines. Must be synchronous to `clk`; the block has no synchronizer.
- `cfg_we_i`  in  1: config write strobe.
- `cfg_id_i`  in  CLIC_ID_WIDTH: source index written.
- `cfg_wdata_i`  in  12: [7:0] level, [8] ie, [9] trig (0 = level, 1 = rising edge), [10] shv, [11] ip (applies to edge sources only).
- `cfg_rdata_o`  out  12: same layout for `cfg_id_i`, combinational. [11] is the current pending bit.
- `irq_ack_i`  in  1: core has taken the interrupt.
- `irq_ack_id_i`  in  CLIC_ID_WIDTH: ID being acknowledged.
- `clic_irq_o`  out  1: an interrupt is presented to the core.
- `clic_irq_id_o`  out  CLIC_ID_WIDTH: ID of the presented interrupt.
- `clic_irq_level_o`  out  8: level of the presented interrupt.
- `clic_irq_priv_o`  out  2: privilege of the presented interrupt. Constant 2'b11 (machine).
- `clic_irq_shv_o`  out  1: the presented interrupt is selectively hardware vectored.

## Operation
- Per-source state registers: `ie`, `trig`, `shv`, `level[7:0]`, `ip`, and `src_q` (previous sample of `intr_src_i`).
- Level-triggered source: `ip <= intr_src_i[i]` every cycle. Config writes and acks do not affect its `ip`.
- Edge-triggered source: `ip` is set when `intr_src_i[i] & !src_q[i]`.
  - Otherwise a cfg write to i loads `cfg_wdata_i[11]`.
  - Otherwise an ack with id i clears `ip`.
  - Priority order: hardware set > cfg write > ack clear.
- Cfg write to any source updates level/ie/trig/shv at the next edge. When trig changes, the new rule applies from the following cycle.
- Cfg writes with `cfg_id_i >= NUM_INTR` are ignored. Reads of such an ID return 0.
- Eligible source: `ip & ie & (level != 0)`. Level-0 sources are never presented.
- Arbitration is combinational over eligible sources:
  - highest `level` wins;
  - on equal level, the higher ID wins.
- Output register: on each edge, `clic_irq_o <= any eligible`.
  - If any source is eligible, id, level and shv load the winner's values.
  - If none is eligible, id, level and shv hold their previous values.
- Acks with `irq_ack_id_i >= NUM_INTR` are ignored.
- Ack on a level-triggered source has no effect. The source must be deasserted externally.
- The block does not compare against mintthresh or mintstatus; that filtering is the core's job.

## Timing
- Reset (`rst` high at an edge):
  - all per-source registers become 0 (level-triggered, disabled, level 0, not pending);
  - `clic_irq_o`, `clic_irq_id_o`, `clic_irq_level_o`, `clic_irq_shv_o` become 0;
  - `clic_irq_priv_o` is always 2'b11;
  - reset mid-operation discards all pending state and in-flight arbitration; `clic_irq_o` is 0 from the first post-reset edge.
- Input-to-output latency: source seen high at edge N → `ip` set after N → `clic_irq_o` high after edge N+1. Latency is 2 edges.
- Ack at edge M (edge source, no new rising edge) → `ip` clear after M → outputs reflect re-arbitration after M+1.
  - In the cycle between M and M+1, `clic_irq_o` may still show the acked ID. The core must tolerate this; it already samples through its own register.
- Cfg write at edge W → effect on eligibility after W → effect on outputs after W+1.
- Simultaneous new rising edge and ack on the same edge source: `ip` stays 1.
- Simultaneous cfg write of ip=0 and rising edge on the same source: `ip` = 1.
- Output id/level/shv change only on an edge. They are never combinational from inputs.

## Test plan
- Reset: drive `intr_src_i` = all 1 with `rst` high for 3 cycles → all outputs 0 and `clic_irq_priv_o` = 2'b11; `cfg_rdata_o` for id 3 reads 0.
- Level source:
  - configure id 4: level 0x40, ie=1, trig=0; raise `intr_src_i[4]` at edge N → `clic_irq_o`=1, id=4, level=0x40 after edge N+1;
  - drop the source → `clic_irq_o`=0 two edges later.
- Priority:
  - id 2 and id 9 both at level 0x80, id 5 at level 0xC0, all pending → presented id=5;
  - then disable id 5 → presented id=9 after 2 edges;
  - set id 9 to level 0 → presented id=2.
- Edge and ack:
  - id 7 edge-triggered with shv=1; pulse the source for 1 cycle → `clic_irq_o`=1, shv=1, and it stays asserted after the source drops;
  - `irq_ack_i` with id 7 → `clic_irq_o`=0 after 2 edges.
- Collision: ack of id 7 on the same edge as a new rising edge on `intr_src_i[7]` → `ip` stays 1 and `clic_irq_o` stays 1.
- Software pend: cfg write of id 11 (edge, ie=1, level 0x10, ip=1) → presented id=11 after 2 edges; a cfg write with ip=0 → `clic_irq_o`=0 after 2 edges.
